// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Free-running event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use interlock, branch squash,
// mult/div occupancy with timeout, memory-wait freeze and perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       fd_rs,
  input  logic [4:0]       fd_rt,
  input  logic             fd_reads_rs,
  input  logic             fd_reads_rt,
  input  logic             dx_is_load,
  input  logic [4:0]       dx_rd,
  input  logic             x_branch_taken,
  input  logic             x_md_start,
  input  logic             x_md_is_div,
  input  logic             md_ready,
  input  logic             mem_wait,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_flush,
  output logic             xm_bubble,
  output logic             md_ctrl_mult,
  output logic             md_ctrl_div,
  output logic             md_result_valid,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int MD_CNT_W = (MD_TIMEOUT < 1) ? 1 : $clog2(MD_TIMEOUT + 1);
  localparam logic [MD_CNT_W-1:0] MD_LIMIT = MD_CNT_W'(MD_TIMEOUT);

  state_t              state_reg, state_next;
  logic [MD_CNT_W-1:0] md_cnt_reg, md_cnt_next;
  logic                md_done_reg, md_done_next;
  logic                load_use;
  logic                md_seen;
  logic                md_exit;
  logic                stall_inc;
  logic                flush_inc;

  assign load_use = dx_is_load && (dx_rd != REG_ZERO) &&
                    ((fd_reads_rs && (fd_rs == dx_rd)) || (fd_reads_rt && (fd_rt == dx_rd)));

  // A ready pulse seen earlier (possibly while frozen) is as good as one seen now.
  assign md_seen = md_done_reg || md_ready;
  assign md_exit = (md_seen || (md_cnt_reg == MD_LIMIT)) && !mem_wait;

  always_comb begin
    pc_en           = 1'b0;
    fd_en           = 1'b0;
    dx_en           = 1'b0;
    xm_en           = 1'b0;
    mw_en           = 1'b0;
    fd_flush        = 1'b0;
    dx_flush        = 1'b0;
    xm_bubble       = 1'b0;
    md_ctrl_mult    = 1'b0;
    md_ctrl_div     = 1'b0;
    md_result_valid = 1'b0;
    md_error        = 1'b0;
    state_next      = state_reg;
    md_cnt_next     = md_cnt_reg;
    md_done_next    = md_done_reg;
    if (reset) begin
      case (state_reg)
        RUN: begin
          {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
          if (mem_wait) begin
            {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b00000;
          end else if (x_branch_taken) begin
            fd_flush = 1'b1;
            dx_flush = 1'b1;
          end else if (x_md_start) begin
            md_ctrl_div  = x_md_is_div;
            md_ctrl_mult = !x_md_is_div;
            pc_en        = 1'b0;
            fd_en        = 1'b0;
            dx_en        = 1'b0;
            xm_bubble    = 1'b1;
            state_next   = MD_BUSY;
            md_cnt_next  = '0;
            md_done_next = 1'b0;
          end else if (load_use) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            dx_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (md_exit) begin
            {pc_en, fd_en, dx_en, xm_en, mw_en} = 5'b11111;
            md_result_valid = 1'b1;
            md_error        = !md_seen;
            state_next      = RUN;
            md_cnt_next     = '0;
            md_done_next    = 1'b0;
          end else begin
            xm_bubble    = 1'b1;
            xm_en        = !mem_wait;
            mw_en        = !mem_wait;
            md_done_next = md_seen;
            // Parks at the limit so a long mem_wait cannot wrap it.
            if (md_cnt_reg != MD_LIMIT) begin
              md_cnt_next = md_cnt_reg + MD_CNT_W'(1);
            end
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= RUN;
      md_cnt_reg  <= '0;
      md_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      md_cnt_reg  <= md_cnt_next;
      md_done_reg <= md_done_next;
    end
  end

  assign stall_inc = reset && !pc_en;
  assign flush_inc = reset && fd_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus random traffic, two instances
// (long timeout / wide counters and short timeout / 4-bit counters) against a model.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic pc, fd, dx, xm, mw, fdf, dxf, xmb, mul, dvd, mrv, err;
  } outs_t;

  localparam int TO_A = 40;
  localparam int TO_B = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] fd_rs, fd_rt, dx_rd;
  logic       fd_reads_rs, fd_reads_rt, dx_is_load;
  logic       x_branch_taken, x_md_start, x_md_is_div, md_ready, mem_wait;

  logic        pc_en[2], fd_en[2], dx_en[2], xm_en[2], mw_en[2];
  logic        fd_flush[2], dx_flush[2], xm_bubble[2];
  logic        md_ctrl_mult[2], md_ctrl_div[2], md_result_valid[2], md_error[2];
  logic [15:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Reference state: is a mult/div outstanding, cycles spent waiting, ready seen.
  bit m_busy[2] = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  bit m_done[2] = '{0, 0};
  int m_stall[2] = '{0, 0};
  int m_flush[2] = '{0, 0};

  always #5 clk = ~clk;

  pipeline_ctrl #(.MD_TIMEOUT(TO_A), .CNT_W(16)) dut_a (
    .clock(clk), .reset(rst_n), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_reads_rs(fd_reads_rs), .fd_reads_rt(fd_reads_rt), .dx_is_load(dx_is_load),
    .dx_rd(dx_rd), .x_branch_taken(x_branch_taken), .x_md_start(x_md_start),
    .x_md_is_div(x_md_is_div), .md_ready(md_ready), .mem_wait(mem_wait),
    .pc_en(pc_en[0]), .fd_en(fd_en[0]), .dx_en(dx_en[0]), .xm_en(xm_en[0]), .mw_en(mw_en[0]),
    .fd_flush(fd_flush[0]), .dx_flush(dx_flush[0]), .xm_bubble(xm_bubble[0]),
    .md_ctrl_mult(md_ctrl_mult[0]), .md_ctrl_div(md_ctrl_div[0]),
    .md_result_valid(md_result_valid[0]), .md_error(md_error[0]),
    .stall_cycles(stall_a), .flush_count(flush_a)
  );

  pipeline_ctrl #(.MD_TIMEOUT(TO_B), .CNT_W(4)) dut_b (
    .clock(clk), .reset(rst_n), .fd_rs(fd_rs), .fd_rt(fd_rt),
    .fd_reads_rs(fd_reads_rs), .fd_reads_rt(fd_reads_rt), .dx_is_load(dx_is_load),
    .dx_rd(dx_rd), .x_branch_taken(x_branch_taken), .x_md_start(x_md_start),
    .x_md_is_div(x_md_is_div), .md_ready(md_ready), .mem_wait(mem_wait),
    .pc_en(pc_en[1]), .fd_en(fd_en[1]), .dx_en(dx_en[1]), .xm_en(xm_en[1]), .mw_en(mw_en[1]),
    .fd_flush(fd_flush[1]), .dx_flush(dx_flush[1]), .xm_bubble(xm_bubble[1]),
    .md_ctrl_mult(md_ctrl_mult[1]), .md_ctrl_div(md_ctrl_div[1]),
    .md_result_valid(md_result_valid[1]), .md_error(md_error[1]),
    .stall_cycles(stall_b), .flush_count(flush_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic outs_t model_out(input int k);
    outs_t o;
    int    to;
    bit    ready_seen;
    bit    lu;
    o = '0;
    to = (k == 0) ? TO_A : TO_B;
    if (!rst_n) return o;
    lu = dx_is_load && dx_rd != 0 &&
         ((fd_reads_rs && fd_rs == dx_rd) || (fd_reads_rt && fd_rt == dx_rd));
    if (!m_busy[k]) begin
      {o.pc, o.fd, o.dx, o.xm, o.mw} = 5'b11111;
      if (mem_wait) begin
        {o.pc, o.fd, o.dx, o.xm, o.mw} = 5'b00000;
      end else if (x_branch_taken) begin
        o.fdf = 1; o.dxf = 1;
      end else if (x_md_start) begin
        o.dvd = x_md_is_div; o.mul = !x_md_is_div;
        o.pc = 0; o.fd = 0; o.dx = 0; o.xmb = 1;
      end else if (lu) begin
        o.pc = 0; o.fd = 0; o.dxf = 1;
      end
    end else begin
      ready_seen = m_done[k] || md_ready;
      if ((ready_seen || m_cnt[k] == to) && !mem_wait) begin
        {o.pc, o.fd, o.dx, o.xm, o.mw} = 5'b11111;
        o.mrv = 1;
        o.err = !ready_seen;
      end else begin
        o.xmb = 1; o.xm = !mem_wait; o.mw = !mem_wait;
      end
    end
    return o;
  endfunction

  function automatic outs_t dut_vec(input int k);
    outs_t o;
    o = '{pc_en[k], fd_en[k], dx_en[k], xm_en[k], mw_en[k], fd_flush[k], dx_flush[k],
          xm_bubble[k], md_ctrl_mult[k], md_ctrl_div[k], md_result_valid[k], md_error[k]};
    return o;
  endfunction

  always @(posedge clk) begin
    outs_t e;
    int    lim;
    for (int k = 0; k < 2; k++) begin
      e   = model_out(k);
      lim = (k == 0) ? 65535 : 15;
      if (!rst_n) begin
        m_busy[k] <= 0; m_cnt[k] <= 0; m_done[k] <= 0; m_stall[k] <= 0; m_flush[k] <= 0;
      end else begin
        if (!e.pc && m_stall[k] < lim) m_stall[k] <= m_stall[k] + 1;
        if (e.fdf && m_flush[k] < lim) m_flush[k] <= m_flush[k] + 1;
        if (!m_busy[k]) begin
          if (e.mul || e.dvd) begin
            m_busy[k] <= 1; m_cnt[k] <= 0; m_done[k] <= 0;
          end
        end else if (e.mrv) begin
          m_busy[k] <= 0; m_cnt[k] <= 0; m_done[k] <= 0;
        end else begin
          if (m_cnt[k] < ((k == 0) ? TO_A : TO_B)) m_cnt[k] <= m_cnt[k] + 1;
          m_done[k] <= m_done[k] | md_ready;
        end
      end
    end
  end

  always @(negedge clk) begin
    assert (!(x_branch_taken && x_md_start)) else $error("branch and md_start coincide");
    if (chk_en) begin
      chk("outs_a", 32'(dut_vec(0)), 32'(model_out(0)));
      chk("outs_b", 32'(dut_vec(1)), 32'(model_out(1)));
      chk("stall_a", 32'(stall_a), 32'(m_stall[0]));
      chk("stall_b", 32'(stall_b), 32'(m_stall[1]));
      chk("flush_a", 32'(flush_a), 32'(m_flush[0]));
      chk("flush_b", 32'(flush_b), 32'(m_flush[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    fd_rs = 0; fd_rt = 0; dx_rd = 0; fd_reads_rs = 0; fd_reads_rt = 0; dx_is_load = 0;
    x_branch_taken = 0; x_md_start = 0; x_md_is_div = 0; md_ready = 0; mem_wait = 0;
  endtask

  initial begin
    rst_n = 0;
    clear_in();
    tick();
    chk_en = 1;
    tick();
    #3;
    chk("rst_pc_en", 32'(pc_en[0]), 0);
    chk("rst_stall", 32'(stall_a), 0);

    tick(); rst_n = 1; #3;
    chk("idle_pc_en", 32'(pc_en[0]), 1);

    // Load-use: one bubble
    tick(); dx_is_load = 1; dx_rd = 5; fd_rs = 5; fd_reads_rs = 1; #3;
    chk("lu_pc_en", 32'(pc_en[0]), 0);
    chk("lu_fd_en", 32'(fd_en[0]), 0);
    chk("lu_dx_flush", 32'(dx_flush[0]), 1);
    chk("lu_dx_en", 32'(dx_en[0]), 1);
    tick(); clear_in(); #3;
    chk("lu_once", 32'(pc_en[0]), 1);
    chk("lu_stall", 32'(stall_a), 1);
    tick(); dx_is_load = 1; dx_rd = 0; fd_rs = 0; fd_reads_rs = 1; #3;
    chk("rd0_no_stall", 32'(pc_en[0]), 1);

    // Branch masks a concurrent load-use
    tick(); clear_in(); x_branch_taken = 1; dx_is_load = 1; dx_rd = 7; fd_rt = 7; fd_reads_rt = 1; #3;
    chk("br_fd_flush", 32'(fd_flush[0]), 1);
    chk("br_dx_flush", 32'(dx_flush[0]), 1);
    chk("br_pc_en", 32'(pc_en[0]), 1);
    tick(); clear_in(); #3;
    chk("br_flush_cnt", 32'(flush_a), 1);
    chk("br_stall", 32'(stall_a), 1);

    // Div with ready at T+5
    tick(); x_md_start = 1; x_md_is_div = 1; #3;
    chk("md_div", 32'(md_ctrl_div[0]), 1);
    chk("md_mult", 32'(md_ctrl_mult[0]), 0);
    chk("md_pc_en", 32'(pc_en[0]), 0);
    for (int i = 1; i <= 4; i++) begin
      tick(); clear_in(); #3;
      chk("md_hold_pc", 32'(pc_en[0]), 0);
      chk("md_no_div", 32'(md_ctrl_div[0]), 0);
      chk("md_no_rv", 32'(md_result_valid[0]), 0);
    end
    tick(); md_ready = 1; #3;
    chk("md_rv", 32'(md_result_valid[0]), 1);
    chk("md_err", 32'(md_error[0]), 0);
    chk("md_exit_pc", 32'(pc_en[0]), 1);
    tick(); clear_in(); #3;
    chk("md_rv_once", 32'(md_result_valid[0]), 0);
    chk("md_stall", 32'(stall_a), 6);

    // Mult with ready hidden under mem_wait T+2..T+6
    tick(); x_md_start = 1; #3;
    chk("mw_mult", 32'(md_ctrl_mult[0]), 1);
    tick(); clear_in();
    tick(); mem_wait = 1;
    tick(); md_ready = 1; #3;
    chk("mw_hold_rv", 32'(md_result_valid[0]), 0);
    for (int i = 4; i <= 6; i++) begin
      tick(); md_ready = 0; mem_wait = 1; #3;
      chk("mw_frozen_rv", 32'(md_result_valid[0]), 0);
    end
    tick(); clear_in(); #3;
    chk("mw_rv", 32'(md_result_valid[0]), 1);
    chk("mw_err", 32'(md_error[0]), 0);

    // Timeout on the short-timeout instance
    tick(); x_md_start = 1;
    for (int i = 1; i <= 4; i++) begin
      tick(); clear_in(); #3;
      chk("to_wait_rv", 32'(md_result_valid[1]), 0);
    end
    tick(); #3;
    chk("to_rv", 32'(md_result_valid[1]), 1);
    chk("to_err", 32'(md_error[1]), 1);
    chk("to_a_busy", 32'(md_result_valid[0]), 0);
    tick(); md_ready = 1; #3;
    chk("to_a_rv", 32'(md_result_valid[0]), 1);
    chk("to_a_err", 32'(md_error[0]), 0);

    // Reset while busy
    tick(); clear_in(); x_md_start = 1;
    tick(); clear_in();
    tick(); rst_n = 0; #3;
    chk("mrst_pc", 32'(pc_en[0]), 0);
    chk("mrst_xmb", 32'(xm_bubble[0]), 0);
    tick(); rst_n = 1; md_ready = 1; #3;
    chk("mrst_run_pc", 32'(pc_en[0]), 1);
    chk("mrst_no_rv", 32'(md_result_valid[0]), 0);
    chk("mrst_stall", 32'(stall_a), 0);
    chk("mrst_flush", 32'(flush_a), 0);

    // Saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      tick(); clear_in(); mem_wait = 1;
    end
    tick(); clear_in(); #3;
    chk("sat_b", 32'(stall_b), 15);
    chk("sat_a", 32'(stall_a), 20);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst_n          = ($urandom_range(0, 149) != 0);
      fd_rs          = 5'($urandom_range(0, 7));
      fd_rt          = 5'($urandom_range(0, 7));
      dx_rd          = 5'($urandom_range(0, 7));
      fd_reads_rs    = 1'($urandom_range(0, 1));
      fd_reads_rt    = 1'($urandom_range(0, 1));
      dx_is_load     = ($urandom_range(0, 2) == 0);
      mem_wait       = ($urandom_range(0, 6) == 0);
      md_ready       = ($urandom_range(0, 9) == 0);
      x_branch_taken = ($urandom_range(0, 9) == 0);
      x_md_start     = !x_branch_taken && ($urandom_range(0, 7) == 0);
      x_md_is_div    = 1'($urandom_range(0, 1));
    end
    tick(); clear_in(); rst_n = 1;
    tick(); #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
